// File: rtl/add_num_job_sequencer_if.sv
// Handshake bundle between the add_num job sequencer and its CSR / CCI-P request neighbours.
// master = the sequencer; slave = the surrounding CSR decode and c0/c1 formatting logic.
interface add_num_job_sequencer_if #(
  parameter int CL_ADDR_W  = 42,
  parameter int DATA_W     = 512,
  parameter int CSR_ADDR_W = 16
);
  logic                  csr_wr_valid;
  logic [CSR_ADDR_W-1:0] csr_wr_addr;
  logic [63:0]           csr_wr_data;

  logic                  rd_almfull;
  logic                  rd_req_valid;
  logic [CL_ADDR_W-1:0]  rd_req_addr;
  logic                  rd_rsp_valid;
  logic [DATA_W-1:0]     rd_rsp_data;

  logic                  wr_almfull;
  logic                  wr_req_valid;
  logic [CL_ADDR_W-1:0]  wr_req_addr;
  logic [DATA_W-1:0]     wr_req_data;
  logic                  wr_rsp_valid;

  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  start_dropped;
  logic [15:0]           job_count;

  modport master (
    input  csr_wr_valid, csr_wr_addr, csr_wr_data,
    input  rd_almfull, rd_rsp_valid, rd_rsp_data,
    input  wr_almfull, wr_rsp_valid,
    output rd_req_valid, rd_req_addr,
    output wr_req_valid, wr_req_addr, wr_req_data,
    output busy, done, error, start_dropped, job_count
  );

  modport slave (
    output csr_wr_valid, csr_wr_addr, csr_wr_data,
    output rd_almfull, rd_rsp_valid, rd_rsp_data,
    output wr_almfull, wr_rsp_valid,
    input  rd_req_valid, rd_req_addr,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    input  busy, done, error, start_dropped, job_count
  );
endinterface

// File: rtl/add_num_job_sequencer.sv
// One add_num job: read a source line, add its two low operands, write the sum to a destination line.
// Every output is a register or a constant-padded copy of one.
module add_num_job_sequencer #(
  parameter int CL_ADDR_W      = 42,
  parameter int DATA_W         = 512,
  parameter int OPERAND_W      = 8,
  parameter int CSR_ADDR_W     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset_n,
  add_num_job_sequencer_if.master      bus
);
  localparam int SUM_W = OPERAND_W + 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [CSR_ADDR_W-1:0] ADDR_SRC  = CSR_ADDR_W'(16'h0020);
  localparam logic [CSR_ADDR_W-1:0] ADDR_DST  = CSR_ADDR_W'(16'h0022);
  localparam logic [CSR_ADDR_W-1:0] ADDR_CTRL = CSR_ADDR_W'(16'h0024);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_ADD,
    ST_WR_REQ,
    ST_WR_WAIT
  } state_t;

  state_t                state_reg;
  logic [CL_ADDR_W-1:0]  src_reg;
  logic [CL_ADDR_W-1:0]  dst_reg;
  logic [CL_ADDR_W-1:0]  job_src_reg;
  logic [CL_ADDR_W-1:0]  job_dst_reg;
  logic [OPERAND_W-1:0]  a_reg;
  logic [OPERAND_W-1:0]  b_reg;
  logic [SUM_W-1:0]      sum_reg;
  logic [TMO_W-1:0]      tmo_reg;

  logic                  rd_req_valid_reg;
  logic [CL_ADDR_W-1:0]  rd_req_addr_reg;
  logic                  wr_req_valid_reg;
  logic [CL_ADDR_W-1:0]  wr_req_addr_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  error_reg;
  logic                  start_dropped_reg;
  logic [15:0]           job_count_reg;

  logic src_wr;
  logic dst_wr;
  logic start_req;
  logic clear_req;

  always_comb begin
    src_wr    = bus.csr_wr_valid && (bus.csr_wr_addr == ADDR_SRC);
    dst_wr    = bus.csr_wr_valid && (bus.csr_wr_addr == ADDR_DST);
    start_req = bus.csr_wr_valid && (bus.csr_wr_addr == ADDR_CTRL) && bus.csr_wr_data[0];
    clear_req = bus.csr_wr_valid && (bus.csr_wr_addr == ADDR_CTRL) && bus.csr_wr_data[1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      src_reg           <= '0;
      dst_reg           <= '0;
      job_src_reg       <= '0;
      job_dst_reg       <= '0;
      a_reg             <= '0;
      b_reg             <= '0;
      sum_reg           <= '0;
      tmo_reg           <= '0;
      rd_req_valid_reg  <= 1'b0;
      rd_req_addr_reg   <= '0;
      wr_req_valid_reg  <= 1'b0;
      wr_req_addr_reg   <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      error_reg         <= 1'b0;
      start_dropped_reg <= 1'b0;
      job_count_reg     <= '0;
    end else begin
      rd_req_valid_reg <= 1'b0;
      wr_req_valid_reg <= 1'b0;

      if (src_wr) src_reg <= bus.csr_wr_data[CL_ADDR_W-1:0];
      if (dst_wr) dst_reg <= bus.csr_wr_data[CL_ADDR_W-1:0];

      // Explicit clear comes first so FSM events in the same cycle still land.
      if (clear_req) begin
        done_reg          <= 1'b0;
        error_reg         <= 1'b0;
        start_dropped_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start_req) begin
            job_src_reg       <= src_reg;
            job_dst_reg       <= dst_reg;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
            start_dropped_reg <= 1'b0;
            busy_reg          <= 1'b1;
            state_reg         <= ST_RD_REQ;
          end
        end

        ST_RD_REQ: begin
          if (!bus.rd_almfull) begin
            rd_req_valid_reg <= 1'b1;
            rd_req_addr_reg  <= job_src_reg;
            tmo_reg          <= '0;
            state_reg        <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (bus.rd_rsp_valid) begin
            a_reg     <= bus.rd_rsp_data[OPERAND_W-1:0];
            b_reg     <= bus.rd_rsp_data[2*OPERAND_W-1:OPERAND_W];
            state_reg <= ST_ADD;
          end else if (tmo_reg == TMO_LAST) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end

        ST_ADD: begin
          sum_reg   <= {1'b0, a_reg} + {1'b0, b_reg};
          state_reg <= ST_WR_REQ;
        end

        ST_WR_REQ: begin
          if (!bus.wr_almfull) begin
            wr_req_valid_reg <= 1'b1;
            wr_req_addr_reg  <= job_dst_reg;
            tmo_reg          <= '0;
            state_reg        <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          if (bus.wr_rsp_valid) begin
            done_reg      <= 1'b1;
            job_count_reg <= job_count_reg + 16'd1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (tmo_reg == TMO_LAST) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase

      // A START seen outside IDLE (including the cycle a response retires the job) is dropped.
      if (start_req && (state_reg != ST_IDLE)) start_dropped_reg <= 1'b1;
    end
  end

  assign bus.rd_req_valid  = rd_req_valid_reg;
  assign bus.rd_req_addr   = rd_req_addr_reg;
  assign bus.wr_req_valid  = wr_req_valid_reg;
  assign bus.wr_req_addr   = wr_req_addr_reg;
  assign bus.wr_req_data   = {{(DATA_W-SUM_W){1'b0}}, sum_reg};
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.error         = error_reg;
  assign bus.start_dropped = start_dropped_reg;
  assign bus.job_count     = job_count_reg;

  logic unused_bits;
  assign unused_bits = ^{bus.csr_wr_data[63:CL_ADDR_W], bus.rd_rsp_data[DATA_W-1:2*OPERAND_W]};
endmodule

// File: tb/tb_add_num_job_sequencer.sv
// Directed bench for add_num_job_sequencer: a table of jobs plus hand-written corner sequences.
module tb_add_num_job_sequencer;
  localparam int CL_ADDR_W      = 42;
  localparam int DATA_W         = 512;
  localparam int OPERAND_W      = 8;
  localparam int CSR_ADDR_W     = 16;
  localparam int TIMEOUT_CYCLES = 4096;

  localparam logic [CSR_ADDR_W-1:0] ADDR_SRC  = 16'h0020;
  localparam logic [CSR_ADDR_W-1:0] ADDR_DST  = 16'h0022;
  localparam logic [CSR_ADDR_W-1:0] ADDR_CTRL = 16'h0024;

  typedef struct {
    logic [CL_ADDR_W-1:0] src;
    logic [CL_ADDR_W-1:0] dst;
    logic [7:0]           a;
    logic [7:0]           b;
    int                   rd_af;
    int                   wr_af;
    logic [8:0]           exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  add_num_job_sequencer_if #(
    .CL_ADDR_W(CL_ADDR_W), .DATA_W(DATA_W), .CSR_ADDR_W(CSR_ADDR_W)
  ) bus ();

  add_num_job_sequencer #(
    .CL_ADDR_W(CL_ADDR_W), .DATA_W(DATA_W), .OPERAND_W(OPERAND_W),
    .CSR_ADDR_W(CSR_ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [15:0] exp_jc = 16'h0000;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rd_req_valid) rd_cnt <= rd_cnt + 1;
    if (bus.wr_req_valid) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [CSR_ADDR_W-1:0] addr, input logic [63:0] data);
    bus.csr_wr_valid = 1'b1;
    bus.csr_wr_addr  = addr;
    bus.csr_wr_data  = data;
    tick();
    bus.csr_wr_valid = 1'b0;
  endtask

  task automatic wait_rd(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.rd_req_valid) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_wr(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.wr_req_valid) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic send_rd_rsp(input logic [7:0] a, input logic [7:0] b);
    logic [DATA_W-1:0] line;
    line = '1;
    line[15:0] = {b, a};
    bus.rd_rsp_valid = 1'b1;
    bus.rd_rsp_data  = line;
    tick();
    bus.rd_rsp_valid = 1'b0;
  endtask

  task automatic send_wr_rsp();
    bus.wr_rsp_valid = 1'b1;
    tick();
    bus.wr_rsp_valid = 1'b0;
  endtask

  task automatic do_job(input vec_t v, input string tag);
    bit seen;
    bit early;
    int t0;
    int rd0;
    int wr0;
    csr_write(ADDR_SRC, 64'(v.src));
    csr_write(ADDR_DST, 64'(v.dst));
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.rd_almfull = (v.rd_af != 0);
    bus.wr_almfull = (v.wr_af != 0);
    t0 = cyc;
    csr_write(ADDR_CTRL, 64'h1);
    early = 1'b0;
    for (int i = 0; i < v.rd_af; i++) begin
      early |= bus.rd_req_valid;
      tick();
    end
    bus.rd_almfull = 1'b0;
    if (v.rd_af != 0) check({tag, " rd_held_by_almfull"}, 64'(early), 64'h0);
    wait_rd(seen);
    check({tag, " rd_req_seen"}, 64'(seen), 64'h1);
    check({tag, " rd_req_addr"}, 64'(bus.rd_req_addr), 64'(v.src));
    if (v.rd_af == 0 && v.wr_af == 0) check({tag, " rd_latency"}, 64'(cyc - t0), 64'd2);
    tick();
    send_rd_rsp(v.a, v.b);
    early = 1'b0;
    for (int i = 0; i < v.wr_af; i++) begin
      early |= bus.wr_req_valid;
      tick();
    end
    bus.wr_almfull = 1'b0;
    if (v.wr_af != 0) check({tag, " wr_held_by_almfull"}, 64'(early), 64'h0);
    wait_wr(seen);
    check({tag, " wr_req_seen"}, 64'(seen), 64'h1);
    check({tag, " wr_req_addr"}, 64'(bus.wr_req_addr), 64'(v.dst));
    check({tag, " wr_sum"}, 64'(bus.wr_req_data[8:0]), 64'(v.exp_sum));
    check({tag, " wr_pad_zero"}, 64'(|bus.wr_req_data[DATA_W-1:9]), 64'h0);
    if (v.rd_af == 0 && v.wr_af == 0) check({tag, " wr_latency"}, 64'(cyc - t0), 64'd6);
    tick();
    send_wr_rsp();
    exp_jc = exp_jc + 16'd1;
    if (v.rd_af == 0 && v.wr_af == 0) check({tag, " done_latency"}, 64'(cyc - t0), 64'd8);
    check({tag, " done"}, 64'(bus.done), 64'h1);
    check({tag, " busy_after"}, 64'(bus.busy), 64'h0);
    check({tag, " error_after"}, 64'(bus.error), 64'h0);
    check({tag, " job_count"}, 64'(bus.job_count), 64'(exp_jc));
    tick();
    tick();
    check({tag, " rd_pulses"}, 64'(rd_cnt - rd0), 64'd1);
    check({tag, " wr_pulses"}, 64'(wr_cnt - wr0), 64'd1);
    $display("job %s src=0x%0h dst=0x%0h a=0x%0h b=0x%0h sum=0x%0h job_count=0x%0h",
             tag, v.src, v.dst, v.a, v.b, bus.wr_req_data[8:0], bus.job_count);
  endtask

  initial begin
    bit seen;
    int rd0;
    int wr0;
    vec_t v;

    vecs[0] = '{src: 42'h100,          dst: 42'h200, a: 8'h12, b: 8'h34, rd_af: 0,  wr_af: 0,  exp_sum: 9'h046};
    vecs[1] = '{src: 42'h3FF_FFFF_FFFF, dst: 42'h1,   a: 8'hFF, b: 8'hFF, rd_af: 0,  wr_af: 0,  exp_sum: 9'h1FE};
    vecs[2] = '{src: 42'h555,          dst: 42'hAAA, a: 8'h80, b: 8'h80, rd_af: 10, wr_af: 0,  exp_sum: 9'h100};
    vecs[3] = '{src: 42'h7,            dst: 42'h8,   a: 8'h01, b: 8'h00, rd_af: 0,  wr_af: 10, exp_sum: 9'h001};
    vecs[4] = '{src: 42'h1234,         dst: 42'h5678, a: 8'h7F, b: 8'h01, rd_af: 3, wr_af: 4,  exp_sum: 9'h080};

    bus.csr_wr_valid = 1'b0;
    bus.csr_wr_addr  = '0;
    bus.csr_wr_data  = '0;
    bus.rd_almfull   = 1'b0;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data  = '0;
    bus.wr_almfull   = 1'b0;
    bus.wr_rsp_valid = 1'b0;

    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("reset busy", 64'(bus.busy), 64'h0);
    check("reset done", 64'(bus.done), 64'h0);
    check("reset error", 64'(bus.error), 64'h0);
    check("reset start_dropped", 64'(bus.start_dropped), 64'h0);
    check("reset job_count", 64'(bus.job_count), 64'h0);
    check("reset req_valids", 64'({bus.rd_req_valid, bus.wr_req_valid}), 64'h0);
    check("reset wr_req_data", 64'(|bus.wr_req_data), 64'h0);

    for (int i = 0; i < 5; i++) do_job(vecs[i], $sformatf("vec%0d", i));

    // Second START while the read is outstanding.
    csr_write(ADDR_SRC, 64'h40);
    csr_write(ADDR_DST, 64'h80);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    csr_write(ADDR_CTRL, 64'h1);
    wait_rd(seen);
    check("drop rd_req_seen", 64'(seen), 64'h1);
    tick();
    csr_write(ADDR_CTRL, 64'h1);
    check("drop start_dropped", 64'(bus.start_dropped), 64'h1);
    check("drop busy", 64'(bus.busy), 64'h1);
    send_rd_rsp(8'h03, 8'h04);
    wait_wr(seen);
    check("drop wr_req_seen", 64'(seen), 64'h1);
    check("drop wr_sum", 64'(bus.wr_req_data[8:0]), 64'h007);
    tick();
    send_wr_rsp();
    exp_jc = exp_jc + 16'd1;
    check("drop done", 64'(bus.done), 64'h1);
    check("drop start_dropped_sticky", 64'(bus.start_dropped), 64'h1);
    check("drop job_count", 64'(bus.job_count), 64'(exp_jc));
    repeat (4) tick();
    check("drop rd_pulses", 64'(rd_cnt - rd0), 64'd1);
    check("drop wr_pulses", 64'(wr_cnt - wr0), 64'd1);
    csr_write(ADDR_CTRL, 64'h2);
    check("clear start_dropped", 64'(bus.start_dropped), 64'h0);
    check("clear done", 64'(bus.done), 64'h0);
    $display("job drop: second START dropped, job_count=0x%0h", bus.job_count);

    // Read response never arrives.
    csr_write(ADDR_SRC, 64'h999);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    csr_write(ADDR_CTRL, 64'h1);
    wait_rd(seen);
    check("tmo rd_req_seen", 64'(seen), 64'h1);
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("tmo error_before", 64'(bus.error), 64'h0);
    check("tmo busy_before", 64'(bus.busy), 64'h1);
    tick();
    check("tmo error", 64'(bus.error), 64'h1);
    check("tmo busy", 64'(bus.busy), 64'h0);
    check("tmo done", 64'(bus.done), 64'h0);
    send_rd_rsp(8'h11, 8'h22);
    repeat (10) tick();
    check("tmo late_rsp busy", 64'(bus.busy), 64'h0);
    check("tmo late_rsp done", 64'(bus.done), 64'h0);
    check("tmo job_count", 64'(bus.job_count), 64'(exp_jc));
    check("tmo rd_pulses", 64'(rd_cnt - rd0), 64'd1);
    check("tmo wr_pulses", 64'(wr_cnt - wr0), 64'd0);
    $display("job tmo: read timed out, error=%0d", bus.error);
    v = '{src: 42'hABC, dst: 42'hDEF, a: 8'h20, b: 8'h22, rd_af: 0, wr_af: 0, exp_sum: 9'h042};
    do_job(v, "after_tmo");

    // Reset pulse while the write is outstanding.
    csr_write(ADDR_SRC, 64'h11);
    csr_write(ADDR_DST, 64'h22);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    csr_write(ADDR_CTRL, 64'h1);
    wait_rd(seen);
    tick();
    send_rd_rsp(8'h01, 8'h02);
    wait_wr(seen);
    check("rst wr_req_seen", 64'(seen), 64'h1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_jc = 16'h0000;
    check("rst busy", 64'(bus.busy), 64'h0);
    check("rst job_count", 64'(bus.job_count), 64'h0);
    check("rst addrs", 64'(bus.rd_req_addr | bus.wr_req_addr), 64'h0);
    check("rst wr_req_data", 64'(|bus.wr_req_data), 64'h0);
    send_wr_rsp();
    repeat (3) tick();
    check("rst stale_rsp done", 64'(bus.done), 64'h0);
    check("rst stale_rsp job_count", 64'(bus.job_count), 64'h0);
    check("rst wr_pulses", 64'(wr_cnt - wr0), 64'd1);
    $display("job rst: reset during write wait, job_count=0x%0h", bus.job_count);

    // Counter wrap from 0xFFFF.
    force dut.job_count_reg = 16'hFFFF;
    tick();
    release dut.job_count_reg;
    tick();
    exp_jc = 16'hFFFF;
    check("wrap preset", 64'(bus.job_count), 64'hFFFF);
    v = '{src: 42'h300, dst: 42'h400, a: 8'h05, b: 8'h06, rd_af: 0, wr_af: 0, exp_sum: 9'h00B};
    do_job(v, "wrap");
    check("wrap job_count_zero", 64'(bus.job_count), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
